// File: rtl/regfile_ctx.sv
// regfile_ctx: register file with a shadow bank for context save/restore.
// A main bank (read on rd1/rd2, written on port 3) is paired with a shadow
// bank. A context request copies registers 1..N-1 one per cycle, either
// main->shadow (save) or shadow->main (restore); register 0 always reads 0.
// Port writes are dropped while a copy is in flight.
// Optional feature: define REGFILE_BYPASS_EN to forward wd3 to a read port
// whose address matches a permitted write in the same cycle.
//
// state      | meaning
// -----------+------------------------------------------------
// ST_IDLE    | port writes allowed, waiting for ctx_req
// ST_SAVE    | copying main[idx] -> shadow[idx], one per cycle
// ST_RESTORE | copying shadow[idx] -> main[idx], one per cycle
module regfile_ctx #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int CR_IDX = 1,
  parameter int HR_IDX = 4,
  parameter int FP_IDX = 30
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we3,
  input  logic [ADDR_W-1:0] ra1,
  input  logic [ADDR_W-1:0] ra2,
  input  logic [ADDR_W-1:0] wa3,
  input  logic [DATA_W-1:0] wd3,
  output logic [DATA_W-1:0] rd1,
  output logic [DATA_W-1:0] rd2,
  output logic [DATA_W-1:0] cr,
  output logic [DATA_W-1:0] hr,
  output logic [DATA_W-1:0] fp,
  input  logic              ctx_req,
  input  logic              ctx_op,
  output logic              ctx_busy,
  output logic              ctx_done
);

  localparam int N = 2 ** ADDR_W;
  // Last index copied; the counter stops here instead of wrapping to 0.
  localparam logic [ADDR_W-1:0] IDX_LAST = '1;
  localparam logic [ADDR_W-1:0] IDX_FIRST = ADDR_W'(1);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SAVE    = 2'd1,
    ST_RESTORE = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic              ctx_done_q, ctx_done_d;

  logic [DATA_W-1:0] main_q   [N];
  logic [DATA_W-1:0] main_d   [N];
  logic [DATA_W-1:0] shadow_q [N];
  logic [DATA_W-1:0] shadow_d [N];

  logic wr_en;

  // A port write lands only while idle and never on register 0.
  assign wr_en = we3 && (wa3 != '0) && (state_q == ST_IDLE);

  // Next-state logic: sequence the copy index and pulse done on the last copy.
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    ctx_done_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (ctx_req) begin
          state_d = ctx_op ? ST_RESTORE : ST_SAVE;
          idx_d   = IDX_FIRST;
        end
      end
      ST_SAVE, ST_RESTORE: begin
        if (idx_q == IDX_LAST) begin
          state_d    = ST_IDLE;
          ctx_done_d = 1'b1;
        end else begin
          idx_d = idx_q + IDX_FIRST;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Bank update: port write (idle only) and the per-cycle context copy.
  always_comb begin
    main_d   = main_q;
    shadow_d = shadow_q;
    if (wr_en) begin
      main_d[wa3] = wd3;
    end
    if (state_q == ST_SAVE) begin
      shadow_d[idx_q] = main_q[idx_q];
    end
    if (state_q == ST_RESTORE) begin
      main_d[idx_q] = shadow_q[idx_q];
    end
  end

  // Control registers; reset aborts any copy without a done pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      idx_q      <= '0;
      ctx_done_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      ctx_done_q <= ctx_done_d;
    end
  end

  // Both banks clear on reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < N; i++) begin
        main_q[i]   <= '0;
        shadow_q[i] <= '0;
      end
    end else begin
      main_q   <= main_d;
      shadow_q <= shadow_d;
    end
  end

  // Read port 1: zero register, optional write-through, else main bank.
  always_comb begin
    rd1 = '0;
    if (ra1 != '0) begin
      rd1 = main_q[ra1];
`ifdef REGFILE_BYPASS_EN
      if (wr_en && (ra1 == wa3)) begin
        rd1 = wd3;
      end
`endif
    end
  end

  // Read port 2: same behaviour as port 1.
  always_comb begin
    rd2 = '0;
    if (ra2 != '0) begin
      rd2 = main_q[ra2];
`ifdef REGFILE_BYPASS_EN
      if (wr_en && (ra2 == wa3)) begin
        rd2 = wd3;
      end
`endif
    end
  end

  assign cr       = main_q[CR_IDX];
  assign hr       = main_q[HR_IDX];
  assign fp       = main_q[FP_IDX];
  assign ctx_busy = (state_q != ST_IDLE);
  assign ctx_done = ctx_done_q;

endmodule

// File: tb/tb_regfile_ctx.sv
// Directed bench for regfile_ctx: inputs change on the falling edge, outputs
// are compared on the falling edge or shortly after an input change.
module tb_regfile_ctx;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              we3 = 1'b0;
  logic [ADDR_W-1:0] ra1 = '0;
  logic [ADDR_W-1:0] ra2 = '0;
  logic [ADDR_W-1:0] wa3 = '0;
  logic [DATA_W-1:0] wd3 = '0;
  logic [DATA_W-1:0] rd1, rd2, cr, hr, fp;
  logic              ctx_req = 1'b0;
  logic              ctx_op = 1'b0;
  logic              ctx_busy, ctx_done;

  int n_vec = 0;
  int n_err = 0;

  regfile_ctx #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .CR_IDX(1), .HR_IDX(4), .FP_IDX(30)
  ) dut (
    .clk(clk), .rst(rst), .we3(we3), .ra1(ra1), .ra2(ra2), .wa3(wa3),
    .wd3(wd3), .rd1(rd1), .rd2(rd2), .cr(cr), .hr(hr), .fp(fp),
    .ctx_req(ctx_req), .ctx_op(ctx_op), .ctx_busy(ctx_busy), .ctx_done(ctx_done)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic do_write(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    @(negedge clk);
    we3 = 1'b1; wa3 = a; wd3 = d;
    @(negedge clk);
    we3 = 1'b0;
  endtask

  task automatic test_reset();
    #3;
    n_vec++; if (rd1 !== 32'd0) begin n_err++; $display("FAIL reset_rd1 got %0d want 0", rd1); end
    n_vec++; if (rd2 !== 32'd0) begin n_err++; $display("FAIL reset_rd2 got %0d want 0", rd2); end
    n_vec++; if ({cr, hr, fp} !== 96'd0) begin n_err++; $display("FAIL reset_taps got %0h want 0", {cr, hr, fp}); end
    n_vec++; if ({ctx_busy, ctx_done} !== 2'b00) begin n_err++; $display("FAIL reset_ctrl got %b want 00", {ctx_busy, ctx_done}); end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_basic();
    do_write(5, 100);
    do_write(7, 200);
    we3 = 1'b0; wa3 = 7; wd3 = 300; ra1 = 5; ra2 = 7;
    #1;
    n_vec++; if (rd1 !== 32'd100) begin n_err++; $display("FAIL basic_rd1 got %0d want 100", rd1); end
    n_vec++; if (rd2 !== 32'd200) begin n_err++; $display("FAIL basic_rd2 got %0d want 200", rd2); end
    @(negedge clk);
    n_vec++; if (rd2 !== 32'd200) begin n_err++; $display("FAIL basic_no_we got %0d want 200", rd2); end
  endtask

  task automatic test_taps();
    do_write(1, 101);
    do_write(4, 202);
    do_write(30, 303);
    n_vec++; if (cr !== 32'd101) begin n_err++; $display("FAIL tap_cr got %0d want 101", cr); end
    n_vec++; if (hr !== 32'd202) begin n_err++; $display("FAIL tap_hr got %0d want 202", hr); end
    n_vec++; if (fp !== 32'd303) begin n_err++; $display("FAIL tap_fp got %0d want 303", fp); end
    do_write(0, 102);
    ra1 = 0; ra2 = 0;
    #1;
    n_vec++; if (rd1 !== 32'd0) begin n_err++; $display("FAIL r0_rd1 got %0d want 0", rd1); end
    n_vec++; if (rd2 !== 32'd0) begin n_err++; $display("FAIL r0_rd2 got %0d want 0", rd2); end
  endtask

  task automatic test_bypass();
    logic [DATA_W-1:0] exp_pre;
`ifdef REGFILE_BYPASS_EN
    exp_pre = 32'd77;
`else
    exp_pre = 32'd0;
`endif
    @(negedge clk);
    we3 = 1'b1; wa3 = 9; wd3 = 77; ra1 = 9;
    #1;
    n_vec++; if (rd1 !== exp_pre) begin n_err++; $display("FAIL bypass_pre got %0d want %0d", rd1, exp_pre); end
    @(negedge clk);
    we3 = 1'b0;
    #1;
    n_vec++; if (rd1 !== 32'd77) begin n_err++; $display("FAIL bypass_post got %0d want 77", rd1); end
  endtask

  task automatic run_ctx(input logic op, input string nm);
    int busy_cnt;
    int done_cnt;
    busy_cnt = 0; done_cnt = 0;
    @(negedge clk);
    ctx_req = 1'b1; ctx_op = op;
    @(negedge clk);
    ctx_req = 1'b0;
    n_vec++; if (ctx_busy !== 1'b1) begin n_err++; $display("FAIL %s_busy_start got %b want 1", nm, ctx_busy); end
    for (int i = 0; i < 60; i++) begin
      busy_cnt += int'(ctx_busy);
      done_cnt += int'(ctx_done);
      @(negedge clk);
    end
    n_vec++; if (busy_cnt != 31) begin n_err++; $display("FAIL %s_busy_cycles got %0d want 31", nm, busy_cnt); end
    n_vec++; if (done_cnt != 1) begin n_err++; $display("FAIL %s_done_pulses got %0d want 1", nm, done_cnt); end
  endtask

  task automatic test_save_restore();
    do_write(5, 100);
    run_ctx(1'b0, "save");
    do_write(5, 555);
    ra1 = 5;
    #1;
    n_vec++; if (rd1 !== 32'd555) begin n_err++; $display("FAIL sr_overwrite got %0d want 555", rd1); end
    run_ctx(1'b1, "restore");
    n_vec++; if (rd1 !== 32'd100) begin n_err++; $display("FAIL sr_restored got %0d want 100", rd1); end
    n_vec++; if (fp !== 32'd303) begin n_err++; $display("FAIL sr_fp got %0d want 303", fp); end
  endtask

  task automatic test_busy_block();
    int busy_cnt;
    int done_cnt;
    busy_cnt = 0; done_cnt = 0;
    @(negedge clk);
    ctx_req = 1'b1; ctx_op = 1'b0;
    @(negedge clk);
    ctx_req = 1'b0;
    for (int i = 0; i < 70; i++) begin
      busy_cnt += int'(ctx_busy);
      done_cnt += int'(ctx_done);
      if (i == 5) begin
        we3 = 1'b1; wa3 = 7; wd3 = 999; ctx_req = 1'b1; ctx_op = 1'b1;
      end
      if (i == 6) begin
        we3 = 1'b0; ctx_req = 1'b0; ctx_op = 1'b0;
      end
      @(negedge clk);
    end
    ra2 = 7;
    #1;
    n_vec++; if (rd2 !== 32'd200) begin n_err++; $display("FAIL busy_write_dropped got %0d want 200", rd2); end
    n_vec++; if (busy_cnt != 31) begin n_err++; $display("FAIL busy_req_ignored_cycles got %0d want 31", busy_cnt); end
    n_vec++; if (done_cnt != 1) begin n_err++; $display("FAIL busy_req_ignored_done got %0d want 1", done_cnt); end
  endtask

  task automatic test_same_edge();
    @(negedge clk);
    we3 = 1'b1; wa3 = 12; wd3 = 32'h1234; ctx_req = 1'b1; ctx_op = 1'b0;
    @(negedge clk);
    we3 = 1'b0; ctx_req = 1'b0;
    for (int i = 0; i < 40; i++) @(negedge clk);
    do_write(12, 32'hdead);
    ra1 = 12;
    #1;
    n_vec++; if (rd1 !== 32'hdead) begin n_err++; $display("FAIL same_edge_overwrite got %0h want dead", rd1); end
    run_ctx(1'b1, "same_edge_restore");
    n_vec++; if (rd1 !== 32'h1234) begin n_err++; $display("FAIL same_edge_saved got %0h want 1234", rd1); end
  endtask

  task automatic test_reset_mid();
    int done_cnt;
    done_cnt = 0;
    @(negedge clk);
    ctx_req = 1'b1; ctx_op = 1'b1;
    @(negedge clk);
    ctx_req = 1'b0;
    for (int i = 0; i < 9; i++) @(negedge clk);
    n_vec++; if (ctx_busy !== 1'b1) begin n_err++; $display("FAIL rst_mid_busy_before got %b want 1", ctx_busy); end
    #2 rst = 1'b1;
    ra1 = 5; ra2 = 7;
    #1;
    n_vec++; if ({ctx_busy, ctx_done} !== 2'b00) begin n_err++; $display("FAIL rst_mid_ctrl got %b want 00", {ctx_busy, ctx_done}); end
    n_vec++; if ({rd1, rd2} !== 64'd0) begin n_err++; $display("FAIL rst_mid_reads got %0h want 0", {rd1, rd2}); end
    n_vec++; if ({cr, hr, fp} !== 96'd0) begin n_err++; $display("FAIL rst_mid_taps got %0h want 0", {cr, hr, fp}); end
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 40; i++) begin
      done_cnt += int'(ctx_done);
      @(negedge clk);
    end
    n_vec++; if (done_cnt != 0) begin n_err++; $display("FAIL rst_mid_no_done got %0d want 0", done_cnt); end
    do_write(3, 5);
    run_ctx(1'b1, "post_rst_restore");
    ra1 = 3;
    #1;
    n_vec++; if (rd1 !== 32'd0) begin n_err++; $display("FAIL rst_shadow_cleared got %0d want 0", rd1); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_taps();
    test_bypass();
    test_save_restore();
    test_busy_block();
    test_same_edge();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
